// File: rtl/timex_fdd_port.sv
`default_nettype none
// timex_fdd_port: port 0x3F drive-control register with a motor hold-off timer
// and a synchronized, read-stable status byte for the Timex FDD interface CPLD.
module timex_fdd_port #(
  parameter int MOTOR_HOLD = 48000000,
  parameter int CNT_W      = 26
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       LS273,
  input  logic       nLS244,
  input  logic [7:0] D_IN,
  output logic [7:0] D_OUT,
  output logic       D_OE,
  input  logic       INDEX,
  input  logic       TRK0,
  input  logic       WPROT,
  input  logic       RDY,
  input  logic       FDC_INT,
  output logic       DS0,
  output logic       DS1,
  output logic       SIDE,
  output logic       DENSITY,
  output logic       FDC_RESET,
  output logic       MOTOR
);

  localparam logic [1:0] M_OFF  = 2'd0;
  localparam logic [1:0] M_ON   = 2'd1;
  localparam logic [1:0] M_HOLD = 2'd2;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(MOTOR_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             ws_meta;
  logic             ws;
  logic             ws_last;
  logic             rd_meta;
  logic             rd_sync_n;
  logic             rs;
  logic             rs_last;
  logic [4:0]       st_meta;
  logic [4:0]       st_sync;
  logic             idx_last;
  logic [7:0]       ctrl;
  logic             fresh;
  logic [1:0]       motor_state;
  logic [CNT_W-1:0] motor_cnt;
  logic             idx_flag;
  logic [7:0]       status_snap;

  logic capture;
  logic rs_fall;
  logic idx_rise;
  logic req_next;
  logic unused_ctrl_bits;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ws_meta   <= 1'b0;
      ws        <= 1'b0;
      ws_last   <= 1'b0;
      rd_meta   <= 1'b1;
      rd_sync_n <= 1'b1;
      rs_last   <= 1'b0;
      st_meta   <= '0;
      st_sync   <= '0;
      idx_last  <= 1'b0;
    end else begin
      ws_meta   <= LS273;
      ws        <= ws_meta;
      ws_last   <= ws;
      rd_meta   <= nLS244;
      rd_sync_n <= rd_meta;
      rs_last   <= rs;
      st_meta   <= {FDC_INT, RDY, WPROT, TRK0, INDEX};
      st_sync   <= st_meta;
      idx_last  <= st_sync[0];
    end
  end

  assign rs       = ~rd_sync_n;
  assign capture  = ws & ~ws_last;
  assign rs_fall  = rs_last & ~rs;
  assign idx_rise = st_sync[0] & ~idx_last;

  // The motor FSM looks at the value being written so it reacts on the
  // capture edge itself; on-time after a clearing write is then MOTOR_HOLD.
  assign req_next = capture ? D_IN[3] : ctrl[3];

  // 'fresh' keeps the controller in reset from power-up until the first write.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ctrl  <= '0;
      fresh <= 1'b1;
    end else if (capture) begin
      ctrl  <= D_IN;
      fresh <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      motor_state <= M_OFF;
      motor_cnt   <= '0;
    end else begin
      case (motor_state)
        M_OFF: begin
          if (req_next) motor_state <= M_ON;
        end
        M_ON: begin
          if (!req_next) begin
            motor_state <= M_HOLD;
            motor_cnt   <= HOLD_LOAD;
          end
        end
        M_HOLD: begin
          if (req_next) begin
            motor_state <= M_ON;
          end else if (motor_cnt == '0) begin
            motor_state <= M_OFF;
          end else begin
            motor_cnt <= motor_cnt - CNT_ONE;
          end
        end
        default: motor_state <= M_OFF;
      endcase
    end
  end

  // Set has priority so an index pulse landing on the end of a read survives.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      idx_flag    <= 1'b0;
      status_snap <= '0;
    end else begin
      if (idx_rise) begin
        idx_flag <= 1'b1;
      end else if (rs_fall) begin
        idx_flag <= 1'b0;
      end
      if (!rs) begin
        status_snap <= {1'b0, idx_flag, MOTOR, st_sync};
      end
    end
  end

  assign MOTOR     = (motor_state != M_OFF);
  assign DS0       = ctrl[0];
  assign DS1       = ctrl[1];
  assign SIDE      = ctrl[2];
  assign FDC_RESET = ctrl[4] | fresh;
  assign DENSITY   = ctrl[5];
  assign D_OUT     = status_snap;
  assign D_OE      = ~nLS244;

  assign unused_ctrl_bits = &{1'b0, ctrl[7:6]};

endmodule

`default_nettype wire

// File: tb/tb_timex_fdd_port.sv
`default_nettype none
// Bench for timex_fdd_port: directed scenarios followed by randomized writes,
// reads and index pulses checked against a cycle-count reference model.
module tb_timex_fdd_port;

  localparam int HOLD = 10;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       LS273 = 1'b0;
  logic       nLS244 = 1'b1;
  logic [7:0] D_IN = 8'h00;
  logic [7:0] D_OUT;
  logic       D_OE;
  logic       INDEX = 1'b0;
  logic       TRK0 = 1'b0;
  logic       WPROT = 1'b0;
  logic       RDY = 1'b0;
  logic       FDC_INT = 1'b0;
  logic       DS0, DS1, SIDE, DENSITY, FDC_RESET, MOTOR;

  always #5 CLK = ~CLK;

  timex_fdd_port #(.MOTOR_HOLD(HOLD), .CNT_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .LS273(LS273), .nLS244(nLS244),
    .D_IN(D_IN), .D_OUT(D_OUT), .D_OE(D_OE),
    .INDEX(INDEX), .TRK0(TRK0), .WPROT(WPROT), .RDY(RDY), .FDC_INT(FDC_INT),
    .DS0(DS0), .DS1(DS1), .SIDE(SIDE), .DENSITY(DENSITY),
    .FDC_RESET(FDC_RESET), .MOTOR(MOTOR)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int edge_no  = 0;

  // Reference model: register contents, "not yet written" flag, edge of the
  // last motor-request clear, and the sticky index flag.
  logic [7:0] m_reg   = 8'h00;
  bit         m_fresh = 1'b1;
  int         m_fall  = -1000;
  bit         m_flag  = 1'b0;
  int         pend_edge = -1;
  logic [7:0] pend_data = 8'h00;
  int         rd_edge = 0;
  bit         m_motor_hist [0:8191];
  bit         d_motor_hist [0:8191];

  function automatic bit exp_motor();
    return m_reg[3] || ((edge_no - m_fall) < HOLD);
  endfunction

  function automatic logic [7:0] exp_ctrl();
    return {2'b00, exp_motor(), m_reg[5], m_reg[4] | m_fresh, m_reg[2], m_reg[1], m_reg[0]};
  endfunction

  function automatic logic [7:0] exp_read();
    return {1'b0, m_flag, m_motor_hist[13'(rd_edge + 1)], FDC_INT, RDY, WPROT, TRK0, INDEX};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    edge_no++;
    if (RESET) begin
      m_reg = 8'h00; m_fresh = 1'b1; m_fall = -1000; m_flag = 1'b0; pend_edge = -1;
    end else if (edge_no == pend_edge) begin
      if (m_reg[3] && !pend_data[3]) m_fall = edge_no;
      m_reg   = pend_data;
      m_fresh = 1'b0;
    end
    m_motor_hist[13'(edge_no)] = exp_motor();
    #1;
    d_motor_hist[13'(edge_no)] = MOTOR;
    chk("ctrl_outputs", {2'b00, MOTOR, DENSITY, FDC_RESET, SIDE, DS1, DS0}, exp_ctrl());
  endtask

  // Strobe of len cycles (len >= 3); D_IN switches to d_after once captured.
  task automatic do_write(input logic [7:0] d, input int len, input logic [7:0] d_after);
    LS273 = 1'b1;
    D_IN  = d;
    pend_edge = edge_no + 3;
    pend_data = d;
    for (int i = 0; i < len; i++) begin
      tick();
      if (i == 2) D_IN = d_after;
    end
    LS273 = 1'b0;
  endtask

  task automatic read_start();
    nLS244 = 1'b0;
    #1;
    chk("d_oe_assert", {7'd0, D_OE}, 8'h01);
    rd_edge = edge_no;
  endtask

  task automatic read_end(input bit index_too);
    nLS244 = 1'b1;
    if (index_too) INDEX = 1'b1;
    #1;
    chk("d_oe_release", {7'd0, D_OE}, 8'h00);
    m_flag = index_too;
  endtask

  task automatic set_status(input logic [4:0] v);
    if (v[0] && !INDEX) m_flag = 1'b1;
    {FDC_INT, RDY, WPROT, TRK0, INDEX} = v;
  endtask

  task automatic index_pulse(input int w);
    if (INDEX) begin
      INDEX = 1'b0;
      repeat (3) tick();
    end
    INDEX  = 1'b1;
    m_flag = 1'b1;
    repeat (w) tick();
    INDEX = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    int c0;
    int cnt;
    bit all_on;

    // Reset
    RESET = 1'b1;
    repeat (2) tick();
    chk("reset_ctrl", {2'b00, MOTOR, DENSITY, FDC_RESET, SIDE, DS1, DS0}, 8'b0000_1000);
    chk("reset_doe", {7'd0, D_OE}, 8'h00);
    RESET = 1'b0;
    repeat (2) tick();
    chk("reset_dout", D_OUT, 8'h00);

    // Write latency and single capture per strobe
    do_write(8'h25, 12, 8'hFF);
    chk("write_25", {2'b00, MOTOR, DENSITY, FDC_RESET, SIDE, DS1, DS0}, 8'b0001_0101);
    repeat (4) tick();
    chk("write_single_capture", {2'b00, MOTOR, DENSITY, FDC_RESET, SIDE, DS1, DS0}, 8'b0001_0101);

    // Motor timeout
    do_write(8'h08, 3, 8'h08);
    repeat (2) tick();
    chk("motor_on", {7'd0, MOTOR}, 8'h01);
    do_write(8'h00, 3, 8'h00);
    c0 = pend_edge;
    repeat (14) tick();
    cnt = 0;
    for (int e = c0; e <= edge_no; e++) if (d_motor_hist[13'(e)]) cnt++;
    chk("motor_on_time", 8'(cnt), 8'(HOLD));
    chk("motor_off_after_hold", {7'd0, MOTOR}, 8'h00);

    // Re-arm at hold cycle 5
    do_write(8'h08, 3, 8'h08);
    repeat (2) tick();
    do_write(8'h00, 3, 8'h00);
    c0 = pend_edge;
    repeat (2) tick();
    do_write(8'h08, 3, 8'h08);
    repeat (15) tick();
    all_on = 1'b1;
    for (int e = c0; e <= edge_no; e++) if (!d_motor_hist[13'(e)]) all_on = 1'b0;
    chk("motor_rearm_no_drop", {7'd0, all_on}, 8'h01);

    // Status read, frozen while the read is in progress
    set_status(5'b00110);
    repeat (4) tick();
    read_start();
    repeat (5) tick();
    chk("status_read", D_OUT, 8'h26);
    WPROT = 1'b0;
    repeat (4) tick();
    chk("status_frozen", D_OUT, 8'h26);
    read_end(1'b0);
    repeat (5) tick();

    // Index flag: set, cleared by a read, and set wins on coincidence
    index_pulse(16);
    read_start();
    repeat (5) tick();
    chk("index_flag_set", {7'd0, D_OUT[6]}, 8'h01);
    chk("index_read_byte", D_OUT, exp_read());
    read_end(1'b0);
    repeat (5) tick();
    read_start();
    repeat (5) tick();
    chk("index_flag_cleared", {7'd0, D_OUT[6]}, 8'h00);
    read_end(1'b1);
    repeat (4) tick();
    INDEX = 1'b0;
    repeat (4) tick();
    read_start();
    repeat (5) tick();
    chk("index_coincident", {7'd0, D_OUT[6]}, 8'h01);
    read_end(1'b0);
    repeat (5) tick();

    // Reset during HOLD
    do_write(8'h00, 3, 8'h00);
    repeat (3) tick();
    chk("hold_active", {7'd0, MOTOR}, 8'h01);
    RESET = 1'b1;
    tick();
    chk("reset_mid_hold", {7'd0, MOTOR}, 8'h00);
    RESET = 1'b0;
    repeat (15) tick();
    chk("hold_not_resumed", {7'd0, MOTOR}, 8'h00);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          do_write(8'($urandom), int'($urandom_range(3, 8)), 8'($urandom));
          repeat ($urandom_range(2, 14)) tick();
        end
        2: begin
          set_status(5'($urandom));
          repeat (4) tick();
          read_start();
          repeat (4) tick();
          chk("rand_read", D_OUT, exp_read());
          read_end(1'b0);
          repeat (4) tick();
        end
        default: index_pulse(int'($urandom_range(1, 6)));
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/timex_fdd_port.md
Name: timex_fdd_port

Overview:
- Clocked register file behind I/O port 0x3F of the Timex FDD interface CPLD.
- Consumes the port write strobe `LS273` and the read strobe `nLS244` from the interface address/port decoder, and replaces the discrete latch/buffer pair.
- Drives the drive-control lines (select, side, motor, density, controller reset) and returns a synchronized status byte.
- Provides a motor hold-off timer and a sticky index-pulse flag.

Parameters:
- `MOTOR_HOLD`, 48000000: CLK cycles the motor stays on after MOTOR_REQ is written 0 (3 s at 16 MHz).
- `CNT_W`, 26: width of the motor counter; must satisfy 2^CNT_W > MOTOR_HOLD.

Ports:
- `CLK`  in  1  system clock, ≥4x Z80 clock
- `RESET`  in  1  synchronous, active-high
- `LS273`  in  1  async port-0x3F write strobe, active high
- `nLS244`  in  1  async port-0x3F read strobe, active low
- `D_IN`  in  8  Z80 data bus, input side
- `D_OUT`  out  8  status byte to data bus
- `D_OE`  out  1  data bus output enable, active high
- `INDEX`, `TRK0`, `WPROT`, `RDY`, `FDC_INT`  in  1 each  async drive/controller status, active high
- `DS0`, `DS1`  out  1 each  drive selects
- `SIDE`  out  1  head select
- `DENSITY`  out  1  density select
- `FDC_RESET`  out  1  controller reset, active high
- `MOTOR`  out  1  spindle motor enable

Behaviour:
- **Reset** (RESET=1 at a CLK edge):
  - control register = 0x00; `DS0`, `DS1`, `SIDE`, `DENSITY`, `MOTOR` = 0.
  - `FDC_RESET` = 1: the controller is held in reset until software clears bit4.
  - Motor counter = 0; index flag = 0; all synchronizer flops = 0 (`nLS244` synchronizer = 1).
  - Reset wins over every simultaneous event.
- **Synchronization:**
  - `LS273`, `nLS244` and the five status inputs each pass through a 2-flop synchronizer.
  - `ws` is the synchronized `LS273`; `rs` is the synchronized, inverted `nLS244`.
- **Write path:**
  - On the cycle `ws` goes 0→1 (edge detected against a third flop), register ← `D_IN`.
  - Latency: register updated 3 CLK edges after `LS273` rises.
  - Exactly one capture per strobe, regardless of strobe length.
  - `D_IN` must stay stable for the whole strobe; the Z80 write cycle guarantees this at the minimum CLK ratio.
- **Register bits:**
  - b0 = `DS0`, b1 = `DS1`, b2 = `SIDE`, b3 = MOTOR_REQ, b4 = `FDC_RESET`, b5 = `DENSITY`.
  - b7:6 are stored but unused.
  - Outputs are driven straight from the register except `MOTOR`.
- **Motor FSM:**
  - States: OFF, ON, HOLD.
  - OFF→ON: MOTOR_REQ = 1.
  - ON→HOLD: MOTOR_REQ = 0; counter loaded with MOTOR_HOLD−1.
  - HOLD: counter decrements by 1 each cycle.
    - HOLD→ON if MOTOR_REQ returns to 1; counter is irrelevant.
    - HOLD→OFF on the cycle the counter is 0.
  - `MOTOR` = 1 in ON and HOLD.
  - Total on-time after the clearing write = MOTOR_HOLD cycles. The counter never wraps.
- **Read path:**
  - `D_OE = ~nLS244`, combinational and unsynchronized, so it meets Z80 read timing.
  - `D_OUT` is a registered snapshot, updated every cycle while `rs` = 0 and frozen while `rs` = 1. This gives a stable byte for the whole read.
  - Bit map: b0 INDEX, b1 TRK0, b2 WPROT, b3 RDY, b4 FDC_INT, b5 `MOTOR`, b6 index flag, b7 0.
- **Index flag:**
  - Set on a synchronized `INDEX` rising edge.
  - Cleared on the cycle `rs` falls, i.e. at the end of a read.
  - If a set and a clear occur in the same cycle, set wins, so no pulse is lost.
- **Simultaneous `ws` and `rs`:** cannot occur on a Z80 bus. If it does happen, both are processed independently.
- **RESET mid-strobe:** the strobe is ignored until `ws` next rises from 0.

Test Plan:
- **Reset:** assert RESET 2 cycles → `DS0`/`DS1`/`SIDE`/`DENSITY`/`MOTOR` = 0, `FDC_RESET` = 1, `D_OE` = 0.
- **Write latency and single capture:** `LS273` high 12 cycles with `D_IN` = 0x25 → exactly 3 edges later `DS0` = 1, `SIDE` = 1, `DENSITY` = 1, `FDC_RESET` = 0, `MOTOR` = 0. Then change `D_IN` to 0xFF while the strobe is still high → no further change.
- **Motor timeout** (`MOTOR_HOLD` = 10):
  - Write 0x08 → `MOTOR` = 1.
  - Write 0x00 → `MOTOR` stays 1 for exactly 10 cycles after the capture edge, then 0.
  - Re-run, writing 0x08 again at hold cycle 5 → `MOTOR` never drops.
- **Status read:** drive `TRK0` = 1, `WPROT` = 1 with `MOTOR` on, assert `nLS244` low → `D_OE` = 1 in the same cycle; after synchronization `D_OUT` = 0x26. Toggle `WPROT` mid-read → `D_OUT` held at 0x26.
- **Index flag:**
  - Pulse `INDEX` for 1 µs, then read → b6 = 1.
  - Read again → b6 = 0.
  - Pulse `INDEX` coincident with the `nLS244` rising edge → the next read shows b6 = 1.
- **Reset mid-hold:** RESET during the HOLD state → `MOTOR` = 0 next cycle and the counter is not resumed.
